vu_meter_ph: RTL and testbench
==============================

# vu_meter_ph

Parametrised multi-channel VU meter with per-channel bar decay, peak-hold dot and sticky clip flags. Sits after the serial ADC front end, in place of the fixed 8-LED comparator meter. Consumes one sample strobe per conversion on the system clock and drives the on-board LED bar for one selectable channel. Thresholds are run-time programmable (base/step), replacing the hard-coded per-Pmod tables.

## Interface
- DATA_W, 12, ADC sample width
- NUM_LED, 8, LEDs in bar (≥2)
- NUM_CH, 2, input channels (≥1)
- HOLD_SAMPLES, 256, per-channel accepted samples a peak dot is held
- DECAY_SAMPLES, 32, per-channel accepted samples per one-LED bar fall
- Derived: LVL_W = clog2(NUM_LED+1), CH_W = max(1, clog2(NUM_CH))

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sample_valid  in  1  one-cycle strobe: sample/sample_ch valid
- sample  in  DATA_W  unsigned ADC code
- sample_ch  in  CH_W  channel of sample; ≥NUM_CH ignored
- base  in  DATA_W  threshold of LED 0
- step  in  DATA_W  threshold increment per LED
- disp_ch  in  CH_W  channel shown on led
- clip_clr  in  1  clears all clip flags
- led  out  NUM_LED  bar + peak dot, registered
- clip  out  NUM_CH  sticky: sample == all-ones seen on channel

## Operation
- Quantise: thr[k] = base + k·step, computed in DATA_W+LVL_W bits (no wrap; thresholds above max code never reached). lvl = count of k in 0..NUM_LED-1 with sample ≥ thr[k]; range 0..NUM_LED. step=0 → lvl ∈ {0, NUM_LED}.
- Per-channel state: bar, peak (LVL_W), dcnt, hcnt (counters), clip bit. Updated only on accepted samples of that channel.
- Bar: lvl ≥ bar → bar=lvl, dcnt=0. Else dcnt==DECAY_SAMPLES-1 → bar=bar-1, dcnt=0. Else dcnt++.
- Peak: lvl ≥ peak → peak=lvl, hcnt=0. Else hcnt==HOLD_SAMPLES-1 → peak=new bar, hcnt=0. Else hcnt++.
- Clip: sample all-ones sets clip[ch]. clip_clr clears all; set in same cycle as clear wins for that channel.
- Display: led[i] = (i < bar[disp_ch]) | (peak[disp_ch]≠0 & i == peak[disp_ch]-1). disp_ch ≥ NUM_CH → led = 0.
- sample_ch ≥ NUM_CH: strobe dropped, no state change.
- base/step sampled with the sample (stage 1); changing them affects later samples only.

## Timing
- Reset (reset=0, async): every bar/peak/dcnt/hcnt/pipeline valid = 0, led = 0, clip = 0. Deassertion synchronous to clk edge; first strobe accepted at the first edge after release.
- Stage 1 (edge E1 after strobe): lvl, ch, clip-hit, valid registered.
- Stage 2 (E2): channel state written.
- Stage 3 (E3): led registered from state of disp_ch. Strobe-to-led latency 3 cycles; disp_ch-to-led 1 cycle.
- Full throughput: strobe every cycle, any channel order; back-to-back same-channel samples each apply in order (stage 2 is the only state reader/writer, no hazard).
- Reset mid-pipeline discards in-flight samples.

## Structure
- Package vu_pkg: LVL_W/CH_W helper functions, thermometer(level) and dot(level) functions, channel state struct.
- Sub-module vu_level_quant (sample, base, step → lvl, combinational), instanced once before stage 1.
- Per-channel state as arrays indexed by channel; no RAM.

## Test plan
- Reset: hold reset=0 with strobes active → led=0, clip=0; release, sample=4095 ch0, base=100, step=300, disp_ch=0 → 3 cycles later led=8'hFF, clip[0]=1.
- Quantiser boundaries (base=100, step=300): samples 99, 100, 399, 400, 2199, 2200 → lvl 0, 1, 1, 2, 7, 8.
- Decay/hold (DECAY=32, HOLD=256): one sample lvl 8 then lvl 0 repeatedly → bar falls one LED every 32 samples; peak dot stays at LED 7 for 255 samples, on 256th drops to bar.
- Channels: alternate ch0 lvl 8 / ch1 lvl 2 every cycle → disp_ch=0 shows 8'hFF, disp_ch=1 shows 8'h03; sample_ch=3 (NUM_CH=2) no effect; disp_ch=3 → led=0.
- Clip: clip_clr and 4095 on ch1 same cycle → clip[1] stays 1, clip[0] cleared.
- Reset mid-operation: assert reset between E1 and E2 → no state update, all outputs 0.

Source files
------------

// File: rtl/vu_pkg.sv
// Shared widths, display helpers and per-channel state record for the VU meter.
// State fields are sized for up to 255 LEDs and 65536-sample hold/decay windows.
package vu_pkg;

  localparam int VU_LVL_MAX_W = 8;
  localparam int VU_CNT_MAX_W = 16;

  function automatic int vu_lvl_w(input int num_led);
    return $clog2(num_led + 1);
  endfunction

  function automatic int vu_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Bar segment idx is lit when the level reaches past it.
  function automatic logic thermometer(input int unsigned level, input int unsigned idx);
    return idx < level;
  endfunction

  function automatic logic dot(input int unsigned level, input int unsigned idx);
    return (level != 0) && (idx == level - 1);
  endfunction

  typedef struct packed {
    logic [VU_LVL_MAX_W-1:0] bar;
    logic [VU_LVL_MAX_W-1:0] peak;
    logic [VU_CNT_MAX_W-1:0] dcnt;
    logic [VU_CNT_MAX_W-1:0] hcnt;
    logic                    clip;
  } vu_ch_st_t;

endpackage

// File: rtl/vu_level_quant.sv
// Combinational quantiser: counts thresholds base + k*step that the sample reaches.
// Thresholds run in DATA_W+LVL_W bits so a large base/step never wraps back into range.
module vu_level_quant
  import vu_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int NUM_LED = 8,
  parameter int LVL_W   = vu_lvl_w(NUM_LED)
) (
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] step,
  output logic [LVL_W-1:0]  lvl
);

  localparam int THR_W = DATA_W + LVL_W;

  logic [THR_W-1:0] thr;
  logic [THR_W-1:0] smp_x;

  assign smp_x = {{LVL_W{1'b0}}, sample};

  always_comb begin
    thr = {{LVL_W{1'b0}}, base};
    lvl = '0;
    for (int k = 0; k < NUM_LED; k++) begin
      if (smp_x >= thr) begin
        lvl = lvl + LVL_W'(1);
      end
      thr = thr + {{LVL_W{1'b0}}, step};
    end
  end

endmodule

// File: rtl/vu_meter_ph.sv
// Multi-channel VU meter: bar decay, peak-hold dot, sticky clip; strobe-to-led 3 cycles, disp_ch-to-led 1.
// No backpressure: accepts a strobe every cycle, out-of-range channels are dropped at stage 1.
module vu_meter_ph
  import vu_pkg::*;
#(
  parameter  int DATA_W        = 12,
  parameter  int NUM_LED       = 8,
  parameter  int NUM_CH        = 2,
  parameter  int HOLD_SAMPLES  = 256,
  parameter  int DECAY_SAMPLES = 32,
  localparam int LVL_W         = vu_lvl_w(NUM_LED),
  localparam int CH_W          = vu_ch_w(NUM_CH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic [DATA_W-1:0]  sample,
  input  logic [CH_W-1:0]    sample_ch,
  input  logic [DATA_W-1:0]  base,
  input  logic [DATA_W-1:0]  step,
  input  logic [CH_W-1:0]    disp_ch,
  input  logic               clip_clr,
  output logic [NUM_LED-1:0] led,
  output logic [NUM_CH-1:0]  clip
);

  localparam logic [VU_CNT_MAX_W-1:0] DCNT_LAST = VU_CNT_MAX_W'(DECAY_SAMPLES - 1);
  localparam logic [VU_CNT_MAX_W-1:0] HCNT_LAST = VU_CNT_MAX_W'(HOLD_SAMPLES - 1);
  localparam logic [VU_CNT_MAX_W-1:0] CNT_ONE   = VU_CNT_MAX_W'(1);
  localparam logic [VU_LVL_MAX_W-1:0] LVL_ONE   = VU_LVL_MAX_W'(1);

  logic [LVL_W-1:0]        q_lvl;
  logic                    s1_vld;
  logic                    s1_hit;
  logic [CH_W-1:0]         s1_ch;
  logic [LVL_W-1:0]        s1_lvl;
  logic [VU_LVL_MAX_W-1:0] lvl_x;
  vu_ch_st_t               st_q [NUM_CH];
  vu_ch_st_t               st_d [NUM_CH];
  logic [NUM_LED-1:0]      led_d;

  vu_level_quant #(
    .DATA_W  (DATA_W),
    .NUM_LED (NUM_LED),
    .LVL_W   (LVL_W)
  ) u_quant (
    .sample (sample),
    .base   (base),
    .step   (step),
    .lvl    (q_lvl)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld <= 1'b0;
      s1_hit <= 1'b0;
      s1_ch  <= '0;
      s1_lvl <= '0;
    end else begin
      s1_vld <= sample_valid && (32'(sample_ch) < 32'(NUM_CH));
      s1_hit <= &sample;
      s1_ch  <= sample_ch;
      s1_lvl <= q_lvl;
    end
  end

  assign lvl_x = VU_LVL_MAX_W'(s1_lvl);

  // Only this stage reads and writes channel state, so back-to-back samples need no bypass.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      st_d[c]      = st_q[c];
      st_d[c].clip = st_q[c].clip & ~clip_clr;
      if (s1_vld && (s1_ch == CH_W'(c))) begin
        if (lvl_x >= st_q[c].bar) begin
          st_d[c].bar  = lvl_x;
          st_d[c].dcnt = '0;
        end else if (st_q[c].dcnt == DCNT_LAST) begin
          st_d[c].bar  = st_q[c].bar - LVL_ONE;
          st_d[c].dcnt = '0;
        end else begin
          st_d[c].dcnt = st_q[c].dcnt + CNT_ONE;
        end

        // A expired hold drops the dot onto the bar as updated by this same sample.
        if (lvl_x >= st_q[c].peak) begin
          st_d[c].peak = lvl_x;
          st_d[c].hcnt = '0;
        end else if (st_q[c].hcnt == HCNT_LAST) begin
          st_d[c].peak = st_d[c].bar;
          st_d[c].hcnt = '0;
        end else begin
          st_d[c].hcnt = st_q[c].hcnt + CNT_ONE;
        end

        if (s1_hit) begin
          st_d[c].clip = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c] <= st_d[c];
      end
    end
  end

  always_comb begin
    led_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (disp_ch == CH_W'(c)) begin
        for (int i = 0; i < NUM_LED; i++) begin
          led_d[i] = thermometer(32'(st_q[c].bar), i) | dot(32'(st_q[c].peak), i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led <= '0;
    end else begin
      led <= led_d;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      clip[c] = st_q[c].clip;
    end
  end

endmodule

// File: tb/tb_vu_meter_ph.sv
// Scoreboard bench for vu_meter_ph (three channels so an out-of-range channel code exists).
// Tagged stimulus cycles push expected {led, clip}; the monitor checks them three edges later.
module tb_vu_meter_ph;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [11:0] sample;
  logic [1:0]  sample_ch;
  logic [11:0] base;
  logic [11:0] step;
  logic [1:0]  disp_ch;
  logic        clip_clr;
  logic [7:0]  led;
  logic [2:0]  clip;

  int total = 0;
  int bad   = 0;

  logic [10:0] exp_q [$];
  string       name_q [$];
  logic        tag_in = 1'b0;
  logic [2:0]  tag_p  = '0;
  logic [10:0] mon_exp;
  string       mon_name;

  int          ck_n [10] = '{1, 31, 32, 63, 64, 95, 96, 255, 256, 257};
  logic [7:0]  ck_l [10] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hBF, 8'h9F, 8'h81, 8'h00, 8'h00};
  logic        d_tg;
  logic [7:0]  d_el;

  always #5 clk = ~clk;

  vu_meter_ph #(
    .DATA_W        (12),
    .NUM_LED       (8),
    .NUM_CH        (3),
    .HOLD_SAMPLES  (256),
    .DECAY_SAMPLES (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .sample_ch    (sample_ch),
    .base         (base),
    .step         (step),
    .disp_ch      (disp_ch),
    .clip_clr     (clip_clr),
    .led          (led),
    .clip         (clip)
  );

  always @(posedge clk) tag_p <= {tag_p[1:0], tag_in};

  always @(negedge clk) begin
    if (tag_p[2]) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty: led=%h clip=%b with nothing expected", led, clip);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if ({led, clip} !== mon_exp) begin
          bad++;
          $display("FAIL %s: got led=%h clip=%b, expected led=%h clip=%b",
                   mon_name, led, clip, mon_exp[10:3], mon_exp[2:0]);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [11:0] s, input logic [1:0] ch,
                     input logic [1:0] dch, input logic clr, input logic tg,
                     input logic [7:0] el, input logic [2:0] ec, input string nm);
    sample_valid = v;
    sample       = s;
    sample_ch    = ch;
    disp_ch      = dch;
    clip_clr     = clr;
    tag_in       = tg;
    if (tg) begin
      exp_q.push_back({el, ec});
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [1:0] dch);
    repeat (n) cyc(1'b0, 12'd0, 2'd0, dch, 1'b0, 1'b0, 8'h00, 3'b000, "");
  endtask

  task automatic do_reset();
    idle(4, 2'd0);
    reset = 1'b0;
    idle(2, 2'd0);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; sample_valid = 1'b0; sample = '0; sample_ch = '0;
    base = 12'd100; step = 12'd300; disp_ch = '0; clip_clr = 1'b0;

    // Reset held with live strobes, then first strobe right after release.
    repeat (4) cyc(1'b1, 12'd4095, 2'd0, 2'd0, 1'b0, 1'b1, 8'h00, 3'b000, "rst_hold");
    idle(3, 2'd0);
    reset = 1'b1;
    cyc(1'b1, 12'd4095, 2'd0, 2'd0, 1'b0, 1'b1, 8'hFF, 3'b001, "first_after_rst");
    idle(3, 2'd0);

    // Clip: clear with a same-cycle strobe, clear colliding with a stage-2 set, plain clear.
    cyc(1'b1, 12'd4095, 2'd1, 2'd0, 1'b1, 1'b1, 8'hFF, 3'b010, "clip_clr_with_strobe");
    idle(3, 2'd0);
    cyc(1'b1, 12'd4095, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00, 3'b000, "");
    cyc(1'b0, 12'd0,    2'd0, 2'd0, 1'b1, 1'b1, 8'hFF, 3'b001, "clip_set_beats_clr");
    idle(3, 2'd0);
    cyc(1'b0, 12'd0,    2'd0, 2'd0, 1'b1, 1'b1, 8'hFF, 3'b000, "clip_clr_only");
    idle(3, 2'd0);

    // Quantiser boundaries on a fresh channel; levels rise so the bar tracks them.
    do_reset();
    cyc(1'b1, 12'd99,   2'd1, 2'd1, 1'b0, 1'b1, 8'h00, 3'b000, "quant_99");
    cyc(1'b1, 12'd100,  2'd1, 2'd1, 1'b0, 1'b1, 8'h01, 3'b000, "quant_100");
    cyc(1'b1, 12'd399,  2'd1, 2'd1, 1'b0, 1'b1, 8'h01, 3'b000, "quant_399");
    cyc(1'b1, 12'd400,  2'd1, 2'd1, 1'b0, 1'b1, 8'h03, 3'b000, "quant_400");
    cyc(1'b1, 12'd2199, 2'd1, 2'd1, 1'b0, 1'b1, 8'h7F, 3'b000, "quant_2199");
    cyc(1'b1, 12'd2200, 2'd1, 2'd1, 1'b0, 1'b1, 8'hFF, 3'b000, "quant_2200");
    idle(3, 2'd1);

    // Decay and hold on channel 2: one full-scale sample then zeros.
    cyc(1'b1, 12'd2200, 2'd2, 2'd2, 1'b0, 1'b1, 8'hFF, 3'b000, "decay_n0");
    for (int n = 1; n <= 257; n++) begin
      d_tg = 1'b0;
      d_el = 8'h00;
      for (int j = 0; j < 10; j++) begin
        if (ck_n[j] == n) begin
          d_tg = 1'b1;
          d_el = ck_l[j];
        end
      end
      cyc(1'b1, 12'd0, 2'd2, 2'd2, 1'b0, d_tg, d_el, 3'b000, $sformatf("decay_n%0d", n));
    end
    idle(3, 2'd2);

    // Interleaved channels, out-of-range sample channel, out-of-range display channel.
    do_reset();
    for (int i = 0; i < 8; i++)
      cyc(1'b1, (i % 2 == 1) ? 12'd400 : 12'd2200, (i % 2 == 1) ? 2'd1 : 2'd0, 2'd0,
          1'b0, i == 3, 8'hFF, 3'b000, "alt_disp0");
    for (int i = 0; i < 8; i++)
      cyc(1'b1, (i % 2 == 1) ? 12'd400 : 12'd2200, (i % 2 == 1) ? 2'd1 : 2'd0, 2'd1,
          1'b0, i == 3, 8'h03, 3'b000, "alt_disp1");
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 12'd4095, 2'd3, 2'd1, 1'b0, i == 3, 8'h03, 3'b000, "bad_sample_ch");
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 12'd0, 2'd0, 2'd3, 1'b0, i == 3, 8'h00, 3'b000, "bad_disp_ch");

    // Reset between E1 and E2 of an in-flight clipping sample.
    cyc(1'b1, 12'd4095, 2'd2, 2'd0, 1'b0, 1'b0, 8'h00, 3'b000, "");
    reset = 1'b0;
    idle(2, 2'd0);
    reset = 1'b1;
    cyc(1'b0, 12'd0,   2'd0, 2'd0, 1'b0, 1'b1, 8'h00, 3'b000, "mid_rst_cleared");
    idle(3, 2'd0);
    cyc(1'b1, 12'd400, 2'd2, 2'd2, 1'b0, 1'b1, 8'h03, 3'b000, "after_mid_rst");
    idle(4, 2'd2);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected responses never checked, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
